// File: rtl/ram_test_pkg.sv
// Shared encodings and LFSR constants for the RAM test sequencer.
package ram_test_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StDrain,
        StFinish
    } state_e;

    typedef enum logic [1:0] {
        PatAddr    = 2'd0,
        PatChecker = 2'd1,
        PatLfsr    = 2'd2,
        PatInvAddr = 2'd3
    } pattern_e;

    // Right-shifting Fibonacci taps: x^16+x^14+x^13+x^11+1 and x^32+x^22+x^2+x+1.
    localparam logic [15:0] LfsrTaps16 = 16'h002D;
    localparam logic [31:0] LfsrTaps32 = 32'hC000_0401;

endpackage

// File: rtl/ram_test_sequencer_if.sv
// RAM-side access bus between the test sequencer (master) and the RAM (slave).
interface ram_test_sequencer_if #(
    parameter int BITWIDTH_SYS = 16,
    parameter int BITWIDTH_ADR = 6
);
    logic                    ram_en;
    logic                    ram_we;
    logic [BITWIDTH_ADR-1:0] ram_adr;
    logic [BITWIDTH_SYS-1:0] ram_wdata;
    logic [BITWIDTH_SYS-1:0] ram_rdata;
    logic                    ram_rdy;

    modport master (
        output ram_en, ram_we, ram_adr, ram_wdata,
        input  ram_rdata, ram_rdy
    );

    modport slave (
        input  ram_en, ram_we, ram_adr, ram_wdata,
        output ram_rdata, ram_rdy
    );
endinterface

// File: rtl/ram_pattern_gen.sv
// Data pattern source: address, checkerboard, LFSR or inverted address.
module ram_pattern_gen
    import ram_test_pkg::*;
#(
    parameter int BITWIDTH_SYS = 16,
    parameter int BITWIDTH_IN  = 12,
    parameter int BITWIDTH_ADR = 6
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    load_i,
    input  logic [BITWIDTH_SYS-1:0] seed_i,
    input  logic                    step_i,
    input  logic [BITWIDTH_ADR-1:0] adr_i,
    input  pattern_e                sel_i,
    output logic [BITWIDTH_SYS-1:0] pattern_o
);
    localparam logic [BITWIDTH_SYS-1:0] Taps = (BITWIDTH_SYS == 32) ?
        BITWIDTH_SYS'(LfsrTaps32) : BITWIDTH_SYS'(LfsrTaps16);
    localparam logic [BITWIDTH_SYS-1:0] One = {{(BITWIDTH_SYS-1){1'b0}}, 1'b1};

    logic [BITWIDTH_SYS-1:0] lfsr_q, lfsr_d, adr_pat;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            // An all-zero LFSR would lock up.
            lfsr_d = (seed_i == '0) ? One : seed_i;
        end else if (step_i) begin
            lfsr_d = {^(lfsr_q & Taps), lfsr_q[BITWIDTH_SYS-1:1]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= One;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    always_comb begin
        adr_pat   = BITWIDTH_SYS'(adr_i) << (BITWIDTH_SYS - BITWIDTH_IN);
        pattern_o = '0;
        unique case (sel_i)
            PatAddr:    pattern_o = adr_pat;
            PatChecker: pattern_o = adr_i[0] ? {(BITWIDTH_SYS/2){2'b01}}
                                             : {(BITWIDTH_SYS/2){2'b10}};
            PatLfsr:    pattern_o = lfsr_q;
            PatInvAddr: pattern_o = ~adr_pat;
            default:    pattern_o = '0;
        endcase
    end

endmodule

// File: rtl/ram_test_sequencer.sv
// Writes a pattern to every RAM address, reads it back and compares the significant MSBs.
module ram_test_sequencer
    import ram_test_pkg::*;
#(
    parameter int BITWIDTH_SYS = 16,
    parameter int BITWIDTH_IN  = 12,
    parameter int BITWIDTH_ADR = 6,
    parameter int RD_LATENCY   = 1
) (
    input  logic                    clk_sys_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic [1:0]              pattern_sel_i,
    input  logic [BITWIDTH_SYS-1:0] seed_i,
    ram_test_sequencer_if.master    ram_bus,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    pass_o,
    output logic [BITWIDTH_ADR:0]   err_cnt_o,
    output logic [BITWIDTH_ADR-1:0] first_err_adr_o
);
    localparam logic [BITWIDTH_SYS-1:0] CmpMask =
        {BITWIDTH_SYS{1'b1}} << (BITWIDTH_SYS - BITWIDTH_IN);
    localparam logic [BITWIDTH_ADR-1:0] LastAdr = '1;

    state_e                  state_q, state_d;
    pattern_e                sel_q, sel_d;
    logic [BITWIDTH_SYS-1:0] seed_q, seed_d;
    logic [BITWIDTH_ADR-1:0] adr_q, adr_d;
    logic                    en_q, en_d, we_q, we_d;
    logic [BITWIDTH_ADR-1:0] ram_adr_q, ram_adr_d;
    logic [BITWIDTH_SYS-1:0] wdata_q, wdata_d;
    logic                    busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [BITWIDTH_ADR:0]   err_q, err_d;
    logic [BITWIDTH_ADR-1:0] first_q, first_d;

    // Stage 0 mirrors the read issue register; stage RD_LATENCY lines up with RAM data.
    logic [RD_LATENCY:0]     vld_q, vld_d;
    logic [BITWIDTH_SYS-1:0] exp_q  [RD_LATENCY+1];
    logic [BITWIDTH_ADR-1:0] padr_q [RD_LATENCY+1];

    logic                    pat_load, pat_step, mismatch;
    logic [BITWIDTH_SYS-1:0] pat_seed, pattern;

    ram_pattern_gen #(
        .BITWIDTH_SYS(BITWIDTH_SYS),
        .BITWIDTH_IN (BITWIDTH_IN),
        .BITWIDTH_ADR(BITWIDTH_ADR)
    ) u_pattern_gen (
        .clk_i    (clk_sys_i),
        .rst_ni   (rst_ni),
        .load_i   (pat_load),
        .seed_i   (pat_seed),
        .step_i   (pat_step),
        .adr_i    (adr_q),
        .sel_i    (sel_q),
        .pattern_o(pattern)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        seed_d    = seed_q;
        adr_d     = adr_q;
        en_d      = 1'b0;
        we_d      = 1'b0;
        ram_adr_d = ram_adr_q;
        wdata_d   = wdata_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        err_d     = err_q;
        first_d   = first_q;
        pat_load  = 1'b0;
        pat_step  = 1'b0;
        pat_seed  = seed_q;
        vld_d     = {vld_q[RD_LATENCY-1:0], 1'b0};

        mismatch = vld_q[RD_LATENCY] &&
                   (((ram_bus.ram_rdata ^ exp_q[RD_LATENCY]) & CmpMask) != '0);
        if (mismatch) begin
            err_d = err_q + 1'b1;
            if (err_q == '0) begin
                first_d = padr_q[RD_LATENCY];
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d  = StWrite;
                    sel_d    = pattern_e'(pattern_sel_i);
                    seed_d   = seed_i;
                    adr_d    = '0;
                    pat_load = 1'b1;
                    pat_seed = seed_i;
                    err_d    = '0;
                    pass_d   = 1'b0;
                    first_d  = '0;
                end
            end
            StWrite: begin
                if (ram_bus.ram_rdy) begin
                    en_d      = 1'b1;
                    we_d      = 1'b1;
                    ram_adr_d = adr_q;
                    wdata_d   = pattern;
                    adr_d     = adr_q + 1'b1;
                    pat_step  = 1'b1;
                    if (adr_q == LastAdr) begin
                        state_d  = StRead;
                        pat_load = 1'b1;
                    end
                end
            end
            StRead: begin
                if (ram_bus.ram_rdy) begin
                    en_d      = 1'b1;
                    ram_adr_d = adr_q;
                    vld_d[0]  = 1'b1;
                    adr_d     = adr_q + 1'b1;
                    pat_step  = 1'b1;
                    if (adr_q == LastAdr) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Leave once the read being compared now is the last one in flight.
                if (vld_q[RD_LATENCY-1:0] == '0) begin
                    state_d = StFinish;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        busy_d = (state_q != StIdle) && (state_d inside {StWrite, StRead, StDrain});
    end

    always_ff @(posedge clk_sys_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            sel_q     <= PatAddr;
            seed_q    <= '0;
            adr_q     <= '0;
            en_q      <= 1'b0;
            we_q      <= 1'b0;
            ram_adr_q <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            first_q   <= '0;
            vld_q     <= '0;
            for (int i = 0; i <= RD_LATENCY; i++) begin
                exp_q[i]  <= '0;
                padr_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            seed_q    <= seed_d;
            adr_q     <= adr_d;
            en_q      <= en_d;
            we_q      <= we_d;
            ram_adr_q <= ram_adr_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            first_q   <= first_d;
            vld_q     <= vld_d;
            exp_q[0]  <= pattern;
            padr_q[0] <= adr_q;
            for (int i = 1; i <= RD_LATENCY; i++) begin
                exp_q[i]  <= exp_q[i-1];
                padr_q[i] <= padr_q[i-1];
            end
        end
    end

    assign ram_bus.ram_en    = en_q;
    assign ram_bus.ram_we    = we_q;
    assign ram_bus.ram_adr   = ram_adr_q;
    assign ram_bus.ram_wdata = wdata_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign pass_o            = pass_q;
    assign err_cnt_o         = err_q;
    assign first_err_adr_o   = first_q;

endmodule

// File: tb/tb_ram_test_sequencer.sv
// Scoreboard bench: two sequencers (read latency 1 and 3) against behavioural RAMs.
module tb_ram_test_sequencer;
    localparam int N = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start1 = 1'b0, start3 = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [15:0] seed = 16'h0;
    logic        busy1, done1, pass1, busy3, done3, pass3;
    logic [6:0]  err1, err3;
    logic [5:0]  fadr1, fadr3;

    ram_test_sequencer_if #(.BITWIDTH_SYS(16), .BITWIDTH_ADR(6)) bus1 ();
    ram_test_sequencer_if #(.BITWIDTH_SYS(16), .BITWIDTH_ADR(6)) bus3 ();

    ram_test_sequencer #(.RD_LATENCY(1)) dut1 (
        .clk_sys_i(clk), .rst_ni(rst_n), .start_i(start1), .pattern_sel_i(sel),
        .seed_i(seed), .ram_bus(bus1), .busy_o(busy1), .done_o(done1), .pass_o(pass1),
        .err_cnt_o(err1), .first_err_adr_o(fadr1)
    );

    ram_test_sequencer #(.RD_LATENCY(3)) dut3 (
        .clk_sys_i(clk), .rst_ni(rst_n), .start_i(start3), .pattern_sel_i(sel),
        .seed_i(seed), .ram_bus(bus3), .busy_o(busy3), .done_o(done3), .pass_o(pass3),
        .err_cnt_o(err3), .first_err_adr_o(fadr3)
    );

    always #5 clk = ~clk;

    int cyc = 0, t0 = 0;
    int errors = 0, checks = 0;
    int fault = 0;
    bit stall = 1'b0;
    int nw1 = 0, nr1 = 0, nw3 = 0, nr3 = 0, nw1_0 = 0, nr1_0 = 0, nw3_0 = 0, nr3_0 = 0;
    int dn1 = 0, dn3 = 0, exp_dn1 = 0, exp_dn3 = 0;
    logic [15:0] mem1 [N];
    logic [15:0] mem3 [N];
    logic [15:0] r3a, r3b;

    typedef struct {
        bit         pass;
        logic [6:0] err;
        logic [5:0] fadr;
        int         dt;
        int         nw;
        int         nr;
    } res_t;
    res_t q1[$], q3[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] corrupt(input logic [15:0] d, input logic [5:0] a);
        case (fault)
            1:       return d & 16'h7FFF;
            2:       return {d[15:4], 4'($urandom)};
            3:       return (a == 6'h2A) ? (d ^ 16'h8000) : d;
            default: return d;
        endcase
    endfunction

    // Behavioural RAMs: latency 1 for dut1, latency 3 for dut3.
    always @(posedge clk) begin
        if (bus1.ram_en && bus1.ram_we) begin
            mem1[bus1.ram_adr] <= bus1.ram_wdata;
            nw1 <= nw1 + 1;
        end
        if (bus1.ram_en && !bus1.ram_we) begin
            bus1.ram_rdata <= corrupt(mem1[bus1.ram_adr], bus1.ram_adr);
            nr1 <= nr1 + 1;
        end
    end

    always @(posedge clk) begin
        if (bus3.ram_en && bus3.ram_we) begin
            mem3[bus3.ram_adr] <= bus3.ram_wdata;
            nw3 <= nw3 + 1;
        end
        if (bus3.ram_en && !bus3.ram_we) begin
            r3a <= corrupt(mem3[bus3.ram_adr], bus3.ram_adr);
            nr3 <= nr3 + 1;
        end
        r3b            <= r3a;
        bus3.ram_rdata <= r3b;
    end

    // Stall every third edge counted from the start edge.
    always @(negedge clk) begin
        bus1.ram_rdy = !(stall && (((cyc - t0 + 1) % 3) == 0));
        bus3.ram_rdy = 1'b1;
    end

    always @(negedge clk) begin : mon1
        res_t r;
        if (rst_n && done1) begin
            dn1++;
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1 unexpected done: got done=1, expected none");
            end else begin
                r = q1.pop_front();
                check("dut1 pass", 32'(pass1), 32'(r.pass));
                check("dut1 err_cnt", 32'(err1), 32'(r.err));
                check("dut1 first_err_adr", 32'(fadr1), 32'(r.fadr));
                check("dut1 done cycle", cyc - t0, r.dt);
                check("dut1 writes", nw1 - nw1_0, r.nw);
                check("dut1 reads", nr1 - nr1_0, r.nr);
                check("dut1 busy at done", 32'(busy1), 0);
            end
        end
    end

    always @(negedge clk) begin : mon3
        res_t r;
        if (rst_n && done3) begin
            dn3++;
            if (q3.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut3 unexpected done: got done=1, expected none");
            end else begin
                r = q3.pop_front();
                check("dut3 pass", 32'(pass3), 32'(r.pass));
                check("dut3 err_cnt", 32'(err3), 32'(r.err));
                check("dut3 first_err_adr", 32'(fadr3), 32'(r.fadr));
                check("dut3 done cycle", cyc - t0, r.dt);
                check("dut3 writes", nw3 - nw3_0, r.nw);
                check("dut3 reads", nr3 - nr3_0, r.nr);
            end
        end
    end

    task automatic run(input bit d3, input logic [1:0] s, input logic [15:0] sd, input int f,
                       input bit st, input bit ep, input int ee, input int ef, input int edt);
        res_t r;
        fault = f;
        stall = st;
        r.pass = ep;
        r.err  = 7'(ee);
        r.fadr = 6'(ef);
        r.dt   = edt;
        r.nw   = N;
        r.nr   = N;
        if (d3) begin
            q3.push_back(r);
            exp_dn3++;
        end else begin
            q1.push_back(r);
            exp_dn1++;
        end
        @(negedge clk);
        sel   = s;
        seed  = sd;
        t0    = cyc + 1;
        nw1_0 = nw1;
        nr1_0 = nr1;
        nw3_0 = nw3;
        nr3_0 = nr3;
        if (d3) start3 = 1'b1;
        else    start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic wait_done(input bit d3);
        int n = 0;
        while (((d3 ? dn3 : dn1) < (d3 ? exp_dn3 : exp_dn1)) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if ((d3 ? dn3 : dn1) < (d3 ? exp_dn3 : exp_dn1)) begin
            checks++;
            errors++;
            $display("FAIL %s done timeout: got no done in %0d cycles", d3 ? "dut3" : "dut1", n);
            if (d3) begin
                void'(q3.pop_front());
                dn3 = exp_dn3;
            end else begin
                void'(q1.pop_front());
                dn1 = exp_dn1;
            end
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " ram_en"}, 32'(bus1.ram_en), 0);
        check({tag, " ram_we"}, 32'(bus1.ram_we), 0);
        check({tag, " ram_adr"}, 32'(bus1.ram_adr), 0);
        check({tag, " ram_wdata"}, 32'(bus1.ram_wdata), 0);
        check({tag, " busy"}, 32'(busy1), 0);
        check({tag, " done"}, 32'(done1), 0);
        check({tag, " pass"}, 32'(pass1), 0);
        check({tag, " err_cnt"}, 32'(err1), 0);
        check({tag, " first_err_adr"}, 32'(fadr1), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #2 rst_n = 1'b0;
        #1 check_reset("por");
        check("por dut3 ram_en", 32'(bus3.ram_en), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Clean address run with START pulses while busy.
        run(1'b0, 2'd0, 16'h0, 0, 1'b0, 1'b1, 0, 0, 130);
        repeat (9) @(negedge clk);
        check("busy mid write", 32'(busy1), 1);
        start1 = 1'b1;
        sel    = 2'd1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (89) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_done(1'b0);
        check("addr mem[5]", 32'(mem1[5]), 32'h0050);
        check("addr mem[63]", 32'(mem1[63]), 32'h03F0);
        repeat (5) @(negedge clk);
        check("pass held", 32'(pass1), 1);
        check("done pulse ended", 32'(done1), 0);

        // Stuck bit 15 with checkerboard: every even address fails.
        run(1'b0, 2'd1, 16'h0, 1, 1'b0, 1'b0, 32, 0, 130);
        wait_done(1'b0);
        check("checker mem[0]", 32'(mem1[0]), 32'hAAAA);
        check("checker mem[1]", 32'(mem1[1]), 32'h5555);

        // LFSR with noisy LSBs, then seed 0.
        run(1'b0, 2'd2, 16'hACE1, 2, 1'b0, 1'b1, 0, 0, 130);
        wait_done(1'b0);
        check("lfsr mem[0]", 32'(mem1[0]), 32'hACE1);
        check("lfsr mem[1]", 32'(mem1[1]), 32'h5670);
        run(1'b0, 2'd2, 16'h0000, 2, 1'b0, 1'b1, 0, 0, 130);
        wait_done(1'b0);
        check("lfsr0 mem[0]", 32'(mem1[0]), 32'h0001);
        check("lfsr0 mem[1]", 32'(mem1[1]), 32'h8000);

        // Inverted address with RAM_RDY low every third cycle: 63 stalls.
        run(1'b0, 2'd3, 16'h0, 0, 1'b1, 1'b1, 0, 0, 193);
        wait_done(1'b0);
        check("inv mem[5]", 32'(mem1[5]), 32'hFFAF);
        stall = 1'b0;

        // Single-cell read fault at 0x2A on the latency-3 instance.
        run(1'b1, 2'd0, 16'h0, 3, 1'b0, 1'b0, 1, 'h2A, 132);
        wait_done(1'b1);

        // Reset in the middle of the read phase, then a full clean run.
        run(1'b0, 2'd0, 16'h0, 0, 1'b0, 1'b1, 0, 0, 130);
        while ((cyc - t0) < 70) @(negedge clk);
        check("read active before reset", 32'(bus1.ram_en), 1);
        rst_n = 1'b0;
        #1 check_reset("mid-run reset");
        void'(q1.pop_back());
        exp_dn1--;
        @(negedge clk);
        rst_n = 1'b1;
        run(1'b0, 2'd0, 16'h0, 0, 1'b0, 1'b1, 0, 0, 130);
        wait_done(1'b0);
        check("post-reset mem[5]", 32'(mem1[5]), 32'h0050);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_test_sequencer.md
# ram_test_sequencer

Self-checking stimulus generator that sits directly upstream of the on-device RAM test skeleton. On a start pulse it writes a selectable data pattern to every RAM address and reads every address back. Each returned word is compared against the regenerated pattern, with the compare restricted to the RAM's significant MSBs. The block reports pass/fail, an error count and the first failing address to the host-side register interface.

## Interface
Parameters:
- BITWIDTH_SYS, 16: device data-bus width; must be 16 or 32.
- BITWIDTH_IN, 12: significant RAM data width, MSB-aligned in the bus word; must be ≤ BITWIDTH_SYS.
- BITWIDTH_ADR, 6: address width; depth N = 2**BITWIDTH_ADR.
- RD_LATENCY, 1: cycles from read issue (RAM_EN=1, RAM_WE=0) to valid RAM_DIN; range 1..4.

Ports:
- CLK_SYS, in, 1: system clock; single clock domain.
- RSTN, in, 1: asynchronous active-low reset.
- START, in, 1: one-cycle run request; ignored unless in IDLE.
- PATTERN_SEL, in, 2: 0 = address, 1 = checkerboard, 2 = LFSR, 3 = inverted address.
- SEED, in, BITWIDTH_SYS: LFSR seed; sampled on accepted START.
- RAM_EN, out, 1: RAM access strobe.
- RAM_WE, out, 1: 1 = write, 0 = read.
- RAM_ADR, out, BITWIDTH_ADR: RAM address.
- RAM_WDATA, out, BITWIDTH_SYS: write data, full bus word.
- RAM_RDATA, in, BITWIDTH_SYS: read data, MSB-aligned.
- RAM_RDY, in, 1: RAM ready; low = stall.
- BUSY, out, 1: high from accepted START until DONE.
- DONE, out, 1: one-cycle completion pulse.
- PASS, out, 1: 1 when ERR_CNT == 0 at DONE.
- ERR_CNT, out, BITWIDTH_ADR+1: number of mismatching read words.
- FIRST_ERR_ADR, out, BITWIDTH_ADR: address of the first mismatch.

## Operation
- FSM states are IDLE, WRITE, READ, DRAIN and FINISH.
- **IDLE:** START=1 samples PATTERN_SEL and SEED, clears ERR_CNT, PASS and FIRST_ERR_ADR, loads the LFSR and sets the address counter to 0. Next state is WRITE.
- **WRITE:** each cycle with RAM_RDY=1 drives RAM_EN=1, RAM_WE=1, RAM_ADR=adr and RAM_WDATA=pattern(adr), then advances adr and the pattern.
  - After address N-1 the LFSR reloads SEED, adr returns to 0 and the state moves to READ.
- **READ:** each cycle with RAM_RDY=1 issues a read of adr. The expected word and the address are pushed into a RD_LATENCY-deep valid/expected/address shift pipe. After N-1 the state moves to DRAIN.
- **DRAIN:** the pipe shifts with RAM_EN=0 until it is empty, which takes RD_LATENCY cycles. Next state is FINISH.
- **FINISH:** DONE=1 and PASS=(ERR_CNT==0) for one cycle, then IDLE.
- **RAM_RDY=0 in WRITE or READ:** RAM_EN=0 and adr and the pattern are held. The compare pipe keeps shifting, so in-flight reads still complete.
- **Compare:** when the pipe output is valid, mismatch = RAM_RDATA[SYS-1 -: IN] != expected[SYS-1 -: IN]. The lower BITWIDTH_SYS-BITWIDTH_IN bits are ignored.
  - A mismatch increments ERR_CNT; the width holds N, so no saturation occurs.
  - The first mismatch of a run latches FIRST_ERR_ADR.
- **Patterns**, all BITWIDTH_SYS wide:
  - Address: adr zero-extended, placed so its LSB sits at bit SYS-IN.
  - Checkerboard: 0xAAAA… for even adr, 0x5555… for odd adr.
  - LFSR: Fibonacci, one step per accepted access; a SEED of 0 is replaced by 1.
  - Inverted address: bitwise NOT of the address pattern.
- Outside WRITE and READ, RAM_WE=0, RAM_EN=0 and RAM_WDATA holds its last value.

## Timing
- Reset values: RAM_EN=0, RAM_WE=0, RAM_ADR=0, RAM_WDATA=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FIRST_ERR_ADR=0, state IDLE, pipe valid bits 0.
- All outputs are registered. START at edge k gives the first write at edge k+1. BUSY rises at k+1 and falls together with the DONE pulse (deasserted in FINISH).
- With no stalls, the first write is at cycle 1 and the last at cycle N. Reads occupy cycles N+1..2N and DRAIN lasts RD_LATENCY cycles. DONE is at cycle 2N+RD_LATENCY+1, so 130 for the defaults.
- Each RAM_RDY=0 cycle in WRITE or READ adds exactly one cycle.
- START during BUSY is ignored; results of the run in progress are unaffected.
- RSTN low mid-run: immediate asynchronous return to reset values, RAM_EN drops within the same cycle, and results are discarded.
- Results (PASS, ERR_CNT, FIRST_ERR_ADR) are held from DONE until the next accepted START.

## Structure
- Shared package `ram_test_pkg`:
  - State encodings.
  - PATTERN_SEL codes.
  - LFSR tap constants: 16-bit x^16+x^14+x^13+x^11+1; 32-bit x^32+x^22+x^2+x+1.
- Sub-module `ram_pattern_gen`: a combinational/registered pattern source with load (seed), step and adr inputs. It is instantiated once and reloaded between the write and read phases.

## Test plan
Defaults throughout (N=64, RD_LATENCY=1), with an ideal RAM model attached.
- **Clean address run:** PATTERN_SEL=0, ideal RAM, RAM_RDY=1 → DONE at cycle 130, PASS=1, ERR_CNT=0; write of adr 5 carries RAM_WDATA=0x0050.
- **Stuck data bit:** PATTERN_SEL=1, RAM_RDATA bit 15 forced to 0 → even addresses fail, ERR_CNT=32, FIRST_ERR_ADR=0, PASS=0.
- **LSB noise ignored:** PATTERN_SEL=2, SEED=0xACE1, RAM returns lower 4 bits randomized → PASS=1. A second run with SEED=0 uses seed 1 and also gives PASS=1.
- **Stalls:** RAM_RDY low on every 3rd cycle → no lost or duplicated addresses, PASS=1; DONE delay equals the stall count in WRITE/READ.
- **Single-cell fault, RD_LATENCY=3:** adr 0x2A read corrupted → ERR_CNT=1, FIRST_ERR_ADR=0x2A, DONE at cycle 132.
- **Reset and busy start:** RSTN pulsed low at cycle 70 → all outputs at reset values, RAM_EN=0 immediately; a new START then gives a full clean run. START pulses issued while BUSY are ignored.
